// File: rtl/cache_mem_responder.sv
// Memory-side responder: in-order request FIFO, fixed-latency access to a 2^TAG_W word store.
// Optional even-parity protection with error injection when CACHE_MEM_PARITY_EN is defined.
module cache_mem_responder #(
    parameter int unsigned TAG_W   = 8,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned QDEPTH  = 4,
    parameter int unsigned LATENCY = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [TAG_W-1:0]  req_tag,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic              rsp_write,
    output logic [TAG_W-1:0]  rsp_tag,
    output logic [DATA_W-1:0] rsp_rdata,
`ifdef CACHE_MEM_PARITY_EN
    input  logic              inj_err,
    output logic              rsp_err,
`endif
    output logic              busy
);

    localparam int unsigned PTR_W = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(QDEPTH + 1);
    localparam int unsigned LAT_W = (LATENCY > 0) ? $clog2(LATENCY + 1) : 1;
    localparam int unsigned DEPTH = 1 << TAG_W;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t state, next_state;

    logic              q_write [QDEPTH];
    logic [TAG_W-1:0]  q_tag   [QDEPTH];
    logic [DATA_W-1:0] q_wdata [QDEPTH];
    logic [PTR_W-1:0]  wr_ptr, rd_ptr;
    logic [CNT_W-1:0]  count;

    logic              wk_write;
    logic [TAG_W-1:0]  wk_tag;
    logic [DATA_W-1:0] wk_wdata;
    logic [LAT_W-1:0]  cnt;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DEPTH-1:0]  written;
    logic [DATA_W-1:0] rd_word;

    logic push, pop, access;

    assign req_ready = (count != CNT_W'(QDEPTH));
    assign push      = req_valid && req_ready;
    assign pop       = (state == IDLE) && (count != '0);
    assign access    = (state == WAIT) && (cnt == LAT_W'(1));
    assign rsp_valid = (state == RESP);
    assign busy      = (count != '0) || (state != IDLE);
    assign rd_word   = mem[wk_tag];

`ifdef CACHE_MEM_PARITY_EN
    logic q_inj [QDEPTH];
    logic wk_inj;
    logic par_mem [DEPTH];
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (count != '0) next_state = WAIT;
            WAIT:    if (cnt == LAT_W'(1)) next_state = RESP;
            RESP:    if (rsp_ready) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Queue slots and store words carry no reset; validity is tracked by count and written bits.
    always_ff @(posedge clk) begin
        if (push) begin
            q_write[wr_ptr] <= req_write;
            q_tag[wr_ptr]   <= req_tag;
            q_wdata[wr_ptr] <= req_wdata;
`ifdef CACHE_MEM_PARITY_EN
            q_inj[wr_ptr]   <= inj_err;
`endif
        end
        if (access && wk_write) begin
            mem[wk_tag] <= wk_wdata;
`ifdef CACHE_MEM_PARITY_EN
            par_mem[wk_tag] <= (^wk_wdata) ^ wk_inj;
`endif
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            cnt       <= '0;
            wk_write  <= 1'b0;
            wk_tag    <= '0;
            wk_wdata  <= '0;
            rsp_write <= 1'b0;
            rsp_tag   <= '0;
            rsp_rdata <= '0;
            written   <= '0;
`ifdef CACHE_MEM_PARITY_EN
            wk_inj    <= 1'b0;
            rsp_err   <= 1'b0;
`endif
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase

            if (pop) begin
                wk_write <= q_write[rd_ptr];
                wk_tag   <= q_tag[rd_ptr];
                wk_wdata <= q_wdata[rd_ptr];
                cnt      <= LAT_W'(LATENCY);
`ifdef CACHE_MEM_PARITY_EN
                wk_inj   <= q_inj[rd_ptr];
`endif
            end else if (state == WAIT) begin
                cnt <= cnt - 1'b1;
            end

            if (access) begin
                rsp_write <= wk_write;
                rsp_tag   <= wk_tag;
                if (wk_write) begin
                    rsp_rdata       <= wk_wdata;
                    written[wk_tag] <= 1'b1;
                end else begin
                    rsp_rdata <= written[wk_tag] ? rd_word : '0;
                end
`ifdef CACHE_MEM_PARITY_EN
                rsp_err <= !wk_write && written[wk_tag] && (par_mem[wk_tag] ^ (^rd_word));
`endif
            end
        end
    end

endmodule

// File: tb/tb_cache_mem_responder.sv
// Scoreboard bench for cache_mem_responder: directed scenarios plus randomized traffic.
module tb_cache_mem_responder;

    localparam int LAT = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_write = 1'b0;
    logic [7:0]  req_tag = '0;
    logic [31:0] req_wdata = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b1;
    logic        rsp_write;
    logic [7:0]  rsp_tag;
    logic [31:0] rsp_rdata;
    logic        busy;
`ifdef CACHE_MEM_PARITY_EN
    logic        inj_err = 1'b0;
    logic        rsp_err;
`endif

    cache_mem_responder #(.TAG_W(8), .DATA_W(32), .QDEPTH(4), .LATENCY(LAT)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_tag(req_tag), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_write(rsp_write),
        .rsp_tag(rsp_tag), .rsp_rdata(rsp_rdata),
`ifdef CACHE_MEM_PARITY_EN
        .inj_err(inj_err), .rsp_err(rsp_err),
`endif
        .busy(busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        bit          w;
        logic [7:0]  tag;
        logic [31:0] data;
        bit          err;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] m_mem [256];
    bit          m_wr  [256];
    bit          m_bad [256];

    int tests = 0;
    int fails = 0;
    int acc_cyc = 0;
    int rise_cyc = 0;
    bit rand_rsp = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    // Reference: the store seen as a plain array updated in acceptance order.
    task automatic model(input bit w, input logic [7:0] t, input logic [31:0] d, input bit inj);
        exp_t e;
        e.w = w;
        e.tag = t;
        if (w) begin
            m_mem[t] = d;
            m_wr[t]  = 1;
            m_bad[t] = inj;
            e.data   = d;
            e.err    = 0;
        end else begin
            e.data = m_wr[t] ? m_mem[t] : 32'h0;
            e.err  = m_wr[t] && m_bad[t];
        end
        exp_q.push_back(e);
    endtask

    task automatic monitor();
        bit          prev_v = 0, prev_hold = 0;
        logic        p_w;
        logic [7:0]  p_tag;
        logic [31:0] p_data;
        exp_t        e;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_v = 0;
                prev_hold = 0;
            end else begin
                if (prev_hold) begin
                    chk("hold_valid", 32'(rsp_valid), 32'd1);
                    chk("hold_tag", 32'(rsp_tag), 32'(p_tag));
                    chk("hold_data", rsp_rdata, p_data);
                    chk("hold_write", 32'(rsp_write), 32'(p_w));
                end
                if (rsp_valid && !prev_v) rise_cyc = cyc;
                if (rsp_valid && rsp_ready) begin
                    if (exp_q.size() == 0) begin
                        tests++;
                        fails++;
                        $display("FAIL unexpected_rsp: got tag %h data %h, required no response", rsp_tag, rsp_rdata);
                    end else begin
                        e = exp_q.pop_front();
                        chk("rsp_write", 32'(rsp_write), 32'(e.w));
                        chk("rsp_tag", 32'(rsp_tag), 32'(e.tag));
                        chk("rsp_rdata", rsp_rdata, e.data);
`ifdef CACHE_MEM_PARITY_EN
                        chk("rsp_err", 32'(rsp_err), 32'(e.err));
`endif
                    end
                end
                prev_v    = rsp_valid;
                prev_hold = rsp_valid && !rsp_ready;
                p_w       = rsp_write;
                p_tag     = rsp_tag;
                p_data    = rsp_rdata;
            end
        end
    endtask

    task automatic do_req(input bit w, input logic [7:0] t, input logic [31:0] d, input bit inj);
        bit ok = 0;
        req_valid = 1;
        req_write = w;
        req_tag   = t;
        req_wdata = d;
`ifdef CACHE_MEM_PARITY_EN
        inj_err   = inj;
`endif
        for (int i = 0; i < 400 && !ok; i++) begin
            @(negedge clk);
            if (req_ready) begin
                model(w, t, d, inj);
                ok = 1;
            end
            @(posedge clk);
            #1;
            if (ok) acc_cyc = cyc;
            if (rand_rsp) rsp_ready = ($urandom_range(0, 3) != 0);
        end
        req_valid = 0;
        if (!ok) begin
            tests++;
            fails++;
            $display("FAIL req_timeout: tag %h not accepted, required acceptance", t);
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 3000 && exp_q.size() != 0; i++) begin
            @(posedge clk);
            #1;
        end
        chk("drain_empty", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        fork
            monitor();
        join_none

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_rsp_tag", 32'(rsp_tag), 32'd0);
        chk("rst_rsp_rdata", rsp_rdata, 32'd0);
        rst = 0;
        @(posedge clk);
        #1;
        chk("rst_req_ready", 32'(req_ready), 32'd1);

        // Cold fill and latency
        do_req(0, 8'h12, 32'h0, 0);
        chk("busy_after_push", 32'(busy), 32'd1);
        drain();
        chk("latency", 32'(rise_cyc - acc_cyc), 32'(LAT + 1));

        // Write then read of the same tag
        do_req(1, 8'h3A, 32'hDEADBEEF, 0);
        do_req(0, 8'h3A, 32'h0, 0);
        drain();

        // Queue full under backpressure
        rsp_ready = 0;
        for (int i = 0; i < 5; i++) do_req(i[0], 8'h60 + 8'(i), 32'h1000 + 32'(i), 0);
        req_valid = 1;
        req_write = 0;
        req_tag   = 8'h77;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("full_req_ready", 32'(req_ready), 32'd0);
        end
        @(posedge clk);
        #1;
        req_valid = 0;
        rsp_ready = 1;
        drain();

        // Backpressure hold
        rsp_ready = 0;
        do_req(0, 8'h61, 32'h0, 0);
        for (int i = 0; i < 50 && !rsp_valid; i++) begin
            @(posedge clk);
            #1;
        end
        chk("bp_valid", 32'(rsp_valid), 32'd1);
        repeat (10) @(posedge clk);
        #1;
        rsp_ready = 1;
        drain();
        repeat (3) @(posedge clk);
        #1;
        chk("bp_single", 32'(rsp_valid), 32'd0);

        // Reset during WAIT with requests queued
        do_req(1, 8'h44, 32'hCAFEF00D, 0);
        drain();
        do_req(0, 8'h44, 32'h0, 0);
        do_req(1, 8'h45, 32'h12345678, 0);
        do_req(0, 8'h45, 32'h0, 0);
        rst = 1;
        #1;
        chk("mid_rst_valid", 32'(rsp_valid), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_tag", 32'(rsp_tag), 32'd0);
        chk("mid_rst_rdata", rsp_rdata, 32'd0);
        chk("mid_rst_write", 32'(rsp_write), 32'd0);
        exp_q.delete();
        for (int i = 0; i < 256; i++) m_wr[i] = 0;
        repeat (2) @(posedge clk);
        #1;
        rst = 0;
        repeat (20) @(posedge clk);
        #1;
        do_req(0, 8'h44, 32'h0, 0);
        drain();

`ifdef CACHE_MEM_PARITY_EN
        // Parity error injection
        do_req(1, 8'h07, 32'h55, 1);
        do_req(0, 8'h07, 32'h0, 0);
        do_req(1, 8'h07, 32'h55, 0);
        do_req(0, 8'h07, 32'h0, 0);
        drain();
`endif

        // Randomized traffic over a small tag pool to exercise same-tag hazards
        rand_rsp = 1;
        for (int n = 0; n < 200; n++) begin
            logic [7:0] t;
            t = ($urandom_range(0, 4) == 0) ? 8'($urandom) : 8'hA0 + 8'($urandom_range(0, 7));
            do_req(1'($urandom_range(0, 1)), t, $urandom, ($urandom_range(0, 5) == 0));
            repeat ($urandom_range(0, 3)) begin
                @(posedge clk);
                #1;
                rsp_ready = ($urandom_range(0, 3) != 0);
            end
        end
        rand_rsp = 0;
        rsp_ready = 1;
        drain();
        repeat (5) @(posedge clk);
        #1;
        chk("final_idle", 32'(busy), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
